// File: rtl/bus_uart_tx_pkg.sv
// Shared definitions for the bus UART: register offsets, serialiser states
// and the STATUS word layout.
package bus_uart_tx_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // bit0 full, bit1 empty, bit2 busy, bit3 ovf, count from bit8 upward
  function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                              input logic busy, input logic ovf,
                                              input logic [15:0] cnt);
    return {8'h00, cnt, 4'h0, ovf, busy, empty, full};
  endfunction

endpackage

// File: rtl/bus_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count; the head entry is read straight from
// the storage registers so a pop can capture it in the same cycle.
module sync_fifo #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [FIFO_AW:0]  count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = DEPTH[FIFO_AW:0];

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (do_push && !do_pop)      count <= count + (FIFO_AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus writes fill a FIFO, a bit-timed
// serialiser drains it onto tx, STATUS is readable for polling.
module bus_uart_tx
  import bus_uart_tx_pkg::*;
#(
  parameter int CLK_DIV = 35,
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wen,
  input  logic [1:0]  waddr,
  input  logic [7:0]  wdata,
  input  logic        ren,
  input  logic [1:0]  raddr,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  tx_state_t          state;
  logic [15:0]        baud;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               ovf;
  logic [7:0]         head;
  logic               full;
  logic               empty;
  logic [FIFO_AW:0]   count;
  logic               push;
  logic               pop;
  logic               bit_done;
  logic               shift;

  assign push     = wen && (waddr == REG_DATA);
  assign bit_done = (baud == 16'd0);
  assign pop      = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_done));
  assign shift    = bit_done && ((state == S_START) || (state == S_DATA));

  sync_fifo #(
    .DATA_W  (8),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Serialiser: each state holds tx for CLK_DIV cycles, counted down to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      baud    <= 16'd0;
      bit_idx <= 3'd0;
      tx      <= 1'b1;
      irq     <= 1'b1;
    end else begin
      irq <= empty && (state == S_IDLE);
      case (state)
        S_IDLE: begin
          if (!empty) begin
            state <= S_START;
            baud  <= DIV_M1;
            tx    <= 1'b0;
          end
        end
        S_START: begin
          if (bit_done) begin
            state   <= S_DATA;
            baud    <= DIV_M1;
            bit_idx <= 3'd0;
            tx      <= shreg[0];
          end else begin
            baud <= baud - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            baud <= DIV_M1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            if (!empty) begin
              state <= S_START;
              baud  <= DIV_M1;
              tx    <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Shift register carries data only; it is reloaded on every pop
  always_ff @(posedge clk) begin
    if (pop)        shreg <= head;
    else if (shift) shreg <= {1'b0, shreg[7:1]};
  end

  // Overflow is judged against full before any same-cycle pop
  always_ff @(posedge clk) begin
    if (rst)                                          ovf <= 1'b0;
    else if (push && full)                            ovf <= 1'b1;
    else if (wen && (waddr == REG_CTRL) && wdata[0])  ovf <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (ren) begin
      if (raddr == REG_STATUS)
        rdata <= pack_status(full, empty, state != S_IDLE, ovf, 16'(count));
      else
        rdata <= 32'd0;
    end
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Scoreboard bench for bus_uart_tx: expected read data and expected serial
// bytes are queued at stimulus time and checked by independent monitors.
module tb_bus_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [1:0]  waddr;
  logic [7:0]  wdata;
  logic        ren;
  logic [1:0]  raddr;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  bus_uart_tx #(.CLK_DIV(4), .FIFO_AW(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .wen   (wen),
    .waddr (waddr),
    .wdata (wdata),
    .ren   (ren),
    .raddr (raddr),
    .rdata (rdata),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        rd_pend = 1'b0;
  logic        dec_en = 1'b0;
  int          abort_req = 0;
  int          abort_ack = 0;
  logic        busy = 1'b0;
  int          k = 0;
  logic [7:0]  shv = 8'h00;
  logic [31:0] exp_rd[$];
  logic [7:0]  exp_byte[$];
  int          starts[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= ren;
  end

  // Read monitor
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_rd.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rdata_unexpected: got 0x%08h with no read queued", rdata);
      end else begin
        check("rdata", rdata, exp_rd.pop_front());
      end
    end
  end

  // Serial decoder: samples mid-bit assuming 4 cycles per bit
  always @(negedge clk) begin
    if (abort_req != abort_ack) begin
      busy      <= 1'b0;
      abort_ack <= abort_req;
    end else if (dec_en) begin
      if (!busy) begin
        if (tx === 1'b0) begin
          busy <= 1'b1;
          k    <= 0;
          starts.push_back(cyc);
        end
      end else begin
        k <= k + 1;
        if ((k + 1) >= 5 && (k + 1) <= 33 && (((k + 1 - 5) % 4) == 0))
          shv[(k + 1 - 5) / 4] <= tx;
        if ((k + 1) == 37) begin
          check("stop_bit", {31'd0, tx}, 32'd1);
          if (exp_byte.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_unexpected: got byte 0x%02h with none queued", shv);
          end else begin
            check("rx_byte", {24'd0, shv}, {24'd0, exp_byte.pop_front()});
          end
          busy <= 1'b0;
        end
      end
    end
  end

  // One bus cycle; called at #1 after an edge, returns at #1 after the next
  task automatic bus(input logic w, input logic [1:0] wa, input logic [7:0] wd,
                     input logic r, input logic [1:0] ra, input logic [31:0] rexp);
    wen = w; waddr = wa; wdata = wd; ren = r; raddr = ra;
    if (r) exp_rd.push_back(rexp);
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(input int max, input string nm);
    int i = 0;
    while (irq !== 1'b1 && i < max) begin
      step(1);
      i++;
    end
    check(nm, {31'd0, irq}, 32'd1);
  endtask

  task automatic wait_starts(input int target, input int max, input string nm);
    int i = 0;
    while (starts.size() < target && i < max) begin
      step(1);
      i++;
    end
    check(nm, starts.size(), target);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat;
    int n0;
    rst = 1'b1; wen = 1'b0; waddr = 2'd0; wdata = 8'h00; ren = 1'b0; raddr = 2'd0;
    step(3);
    rst = 1'b0;

    // Reset state
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_irq", {31'd0, irq}, 32'd1);
    check("reset_rdata", rdata, 32'd0);
    bus(0, 2'd0, 8'h00, 1, 2'd1, 32'h0000_0002);
    dec_en = 1'b1;

    // Single byte 0x55 with bit-exact waveform
    exp_byte.push_back(8'h55);
    bus(1, 2'd0, 8'h55, 0, 2'd0, 32'd0);
    check("start_not_yet", {31'd0, tx}, 32'd1);
    step(1);
    check("irq_busy", {31'd0, irq}, 32'd0);
    pat = 10'b1010101010;
    for (int b = 0; b < 10; b++) begin
      check("bit_begin", {31'd0, tx}, {31'd0, pat[b]});
      step(3);
      check("bit_end", {31'd0, tx}, {31'd0, pat[b]});
      step(1);
    end
    wait_irq(10, "irq_after_55");

    // Back-to-back bytes
    n0 = starts.size();
    exp_byte.push_back(8'hA5);
    exp_byte.push_back(8'h3C);
    bus(1, 2'd0, 8'hA5, 0, 2'd0, 32'd0);
    bus(1, 2'd0, 8'h3C, 0, 2'd0, 32'd0);
    wait_starts(n0 + 2, 100, "two_frames");
    if (starts.size() >= n0 + 2)
      check("frame_spacing", starts[n0 + 1] - starts[n0], 40);
    wait_irq(100, "irq_after_pair");

    // Overfill: 18 writes, one popped early, 16 stored, last one dropped
    for (int i = 0; i < 18; i++) begin
      if (i < 17) exp_byte.push_back(8'(i));
      bus(1, 2'd0, 8'(i), 0, 2'd0, 32'd0);
    end
    bus(0, 2'd0, 8'h00, 1, 2'd1, 32'h0000_100D);
    bus(1, 2'd2, 8'h01, 0, 2'd0, 32'd0);
    bus(0, 2'd0, 8'h00, 1, 2'd1, 32'h0000_1005);
    wait_irq(900, "irq_after_fill");
    check("fill_all_sent", exp_byte.size(), 0);

    // Reset in the middle of a frame's data bits
    n0 = starts.size();
    exp_byte.push_back(8'h11);
    exp_byte.push_back(8'h22);
    bus(1, 2'd0, 8'h11, 0, 2'd0, 32'd0);
    bus(1, 2'd0, 8'h22, 0, 2'd0, 32'd0);
    step(15);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_byte.delete();
    abort_req++;
    check("tx_after_rst", {31'd0, tx}, 32'd1);
    bus(0, 2'd0, 8'h00, 1, 2'd1, 32'h0000_0002);
    step(100);
    check("no_frames_after_rst", starts.size(), n0 + 1);
    check("tx_idle_after_rst", {31'd0, tx}, 32'd1);

    // Reserved offset, zero-reading registers, simultaneous write and read
    bus(1, 2'd3, 8'hFF, 0, 2'd0, 32'd0);
    bus(0, 2'd0, 8'h00, 1, 2'd1, 32'h0000_0002);
    bus(0, 2'd0, 8'h00, 1, 2'd0, 32'h0000_0000);
    bus(0, 2'd0, 8'h00, 1, 2'd1, 32'h0000_0002);
    bus(0, 2'd0, 8'h00, 1, 2'd2, 32'h0000_0000);
    bus(0, 2'd0, 8'h00, 1, 2'd3, 32'h0000_0000);
    exp_byte.push_back(8'h5A);
    bus(1, 2'd0, 8'h5A, 1, 2'd1, 32'h0000_0002);
    bus(0, 2'd0, 8'h00, 1, 2'd1, 32'h0000_0100);
    wait_irq(100, "irq_after_5a");

    step(2);
    check("rd_queue_drained", exp_rd.size(), 0);
    check("byte_queue_drained", exp_byte.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
